// File: rtl/video_timing_pkg.sv
// Shared definitions for the frame/line timing generator: FSM state encoding
// and the default full-resolution sensor geometry.
package video_timing_pkg;

   // state  | meaning
   // IDLE   | waiting for start, V=0 H=0
   // VSETUP | frame setup, V=1 H=0
   // ACTIVE | active pixels of one line, V=1 H=1
   // HBLANK | line blanking, V=1 H=0
   // VBLANK | frame blanking, V=0 H=0
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      VSETUP = 3'd1,
      ACTIVE = 3'd2,
      HBLANK = 3'd3,
      VBLANK = 3'd4
   } vtState_e;

   localparam int DEF_H_ACTIVE = 2448;
   localparam int DEF_V_ACTIVE = 2048;
   localparam int DEF_H_BLANK  = 64;
   localparam int DEF_V_SETUP  = 16;
   localparam int DEF_V_BLANK  = 32;
   localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/video_timing_gen.sv
// Frame/line strobe generator. Produces outV/outH for the pixel-capture path,
// runs a counted number of frames (or continuously when frames==0), and
// reports progress via busy, line_idx, frame_cnt and frame_done.
//
// state  | meaning
// IDLE   | waiting for start
// VSETUP | V high, H low before the first line
// ACTIVE | V and H high, one line of pixels
// HBLANK | V high, H low after every line
// VBLANK | V low between frames; frame_done pulses on its first cycle
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int H_BLANK  = DEF_H_BLANK,
   parameter int V_SETUP  = DEF_V_SETUP,
   parameter int V_BLANK  = DEF_V_BLANK,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [7:0]       frames,
   output logic             outV,
   output logic             outH,
   output logic [CNT_W-1:0] line_idx,
   output logic [7:0]       frame_cnt,
   output logic             busy,
   output logic             frame_done
);

   localparam logic [CNT_W-1:0] H_ACTIVE_M1 = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] H_BLANK_M1  = CNT_W'(H_BLANK - 1);
   localparam logic [CNT_W-1:0] V_SETUP_M1  = CNT_W'(V_SETUP - 1);
   localparam logic [CNT_W-1:0] V_BLANK_M1  = CNT_W'(V_BLANK - 1);
   localparam logic [CNT_W-1:0] LAST_LINE   = CNT_W'(V_ACTIVE - 1);

   vtState_e         state;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       framesReg;
   logic             stopPend;

   // Single FSM: one shared down-counter times every state; all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         framesReg  <= '0;
         stopPend   <= 1'b0;
         outV       <= 1'b0;
         outH       <= 1'b0;
         line_idx   <= '0;
         frame_cnt  <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         // Stop is remembered while running; the IDLE entry below clears it.
         if (state != IDLE && stop) begin
            stopPend <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  // A stop in the same cycle as start limits the run to one frame.
                  framesReg <= frames;
                  frame_cnt <= '0;
                  stopPend  <= stop;
                  state     <= VSETUP;
                  cnt       <= V_SETUP_M1;
                  outV      <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            VSETUP: begin
               if (cnt == '0) begin
                  state    <= ACTIVE;
                  cnt      <= H_ACTIVE_M1;
                  outH     <= 1'b1;
                  line_idx <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ACTIVE: begin
               if (cnt == '0) begin
                  state <= HBLANK;
                  cnt   <= H_BLANK_M1;
                  outH  <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HBLANK: begin
               if (cnt == '0) begin
                  if (line_idx < LAST_LINE) begin
                     state    <= ACTIVE;
                     cnt      <= H_ACTIVE_M1;
                     outH     <= 1'b1;
                     line_idx <= line_idx + 1'b1;
                  end else begin
                     state      <= VBLANK;
                     cnt        <= V_BLANK_M1;
                     outV       <= 1'b0;
                     frame_done <= 1'b1;
                     frame_cnt  <= frame_cnt + 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            VBLANK: begin
               if (cnt == '0) begin
                  // frame_cnt already holds this frame's increment here.
                  if (stopPend || stop || (framesReg != '0 && frame_cnt == framesReg)) begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     stopPend <= 1'b0;
                  end else begin
                     state <= VSETUP;
                     cnt   <= V_SETUP_M1;
                     outV  <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               outV  <= 1'b0;
               outH  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Frame/line timing generator that sequences the pixel-capture datapath of the simulation and sensor-emulation chain. It produces the `outV`/`outH` frame and line strobes that the image source and downstream blocks treat as their capture qualifier (`V & H` marks one active pixel). It runs a configurable number of frames, or runs continuously, with programmable setup and blanking intervals. It reports progress through status outputs.

## Interface
- `H_ACTIVE`, default 2448: active pixels per line, ≥1.
- `V_ACTIVE`, default 2048: active lines per frame, ≥1.
- `H_BLANK`, default 64: cycles with H low after every line, including the last, ≥1.
- `V_SETUP`, default 16: cycles with V high and H low before the first line, ≥1.
- `V_BLANK`, default 32: cycles with V low between frames, ≥1.
- `CNT_W`, default 16: width of the pixel and line counters; must hold `max(H_ACTIVE, V_ACTIVE, H_BLANK, V_SETUP, V_BLANK)`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin; honoured only in IDLE.
- `stop`  in  1  one-cycle request; finish the current frame, then go IDLE.
- `frames`  in  8  frame count, sampled on an accepted `start`; 0 means continuous.
- `outV`  out  1  frame valid.
- `outH`  out  1  line/pixel valid.
- `line_idx`  out  CNT_W  current active line, 0..V_ACTIVE-1.
- `frame_cnt`  out  8  frames completed since the last accepted start; wraps modulo 256.
- `busy`  out  1  high from the cycle after an accepted start until the return to IDLE.
- `frame_done`  out  1  one-cycle pulse per completed frame.

## Operation
- All outputs are registered. Reset value of every output is 0, and the FSM resets to IDLE.
- `rst` mid-frame aborts immediately: all outputs are 0 on the next cycle and the pending stop is cleared.
- FSM states and behaviour:
  - **IDLE**: V=0, H=0. An accepted `start` latches `frames`, clears `frame_cnt`, and moves to VSETUP.
  - **VSETUP**: V=1, H=0 for V_SETUP cycles, then ACTIVE with `line_idx`=0.
  - **ACTIVE**: V=1, H=1 for H_ACTIVE cycles, then HBLANK.
  - **HBLANK**: V=1, H=0 for H_BLANK cycles. Next is ACTIVE with `line_idx`+1 if `line_idx` < V_ACTIVE-1; otherwise VBLANK.
  - **VBLANK**: V=0, H=0 for V_BLANK cycles. At exit:
    - go to IDLE if a stop is pending, or if `frames`≠0 and `frame_cnt` equals `frames`;
    - otherwise go to VSETUP.
- `frame_done` pulses, and `frame_cnt` increments, on the first VBLANK cycle.
- A single down-counter (`CNT_W` bits) is loaded with the state length minus 1 on each state entry; the state ends when it reaches 0.
- `stop` sets a sticky pending flag in any non-IDLE state. It is cleared on entry to IDLE.
- `stop` in IDLE alone is ignored.
- `start` and `stop` in the same IDLE cycle: start is accepted and stop is latched pending, so exactly one frame runs.
- `start` while busy is ignored, and `frames` is not resampled.
- `frame_cnt` wrap in continuous mode is harmless. In counted mode the comparison uses the pre-wrap value; `frames` ≤ 255, so the count never wraps there.

## Timing
- `start` accepted at cycle N → first VSETUP cycle, with `outV`=1 and `busy`=1, at N+1.
- Frame period is P = V_SETUP + V_ACTIVE·(H_ACTIVE+H_BLANK) + V_BLANK cycles.
- The next frame's VSETUP immediately follows VBLANK, with no idle cycle.
- `busy` is high for exactly k·P cycles for k frames, and falls in the cycle after the last VBLANK cycle.
- `line_idx` updates on the first ACTIVE cycle of each line and holds through that line's HBLANK.
- The downstream source adds 2 cycles of strobe delay; that is outside this block.

## Structure
- Shared package `video_timing_pkg`:
  - FSM state enum (IDLE, VSETUP, ACTIVE, HBLANK, VBLANK);
  - default geometry constants (2448×2048, blanking defaults).
- No sub-module; the single FSM plus one down-counter and the line/frame counters are sufficient.

## Test plan
All scenarios use small geometry: H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_SETUP=2, V_BLANK=3, giving P=23.
- `frames`=1, `start` pulse → `outV` high 20 cycles; three `outH` bursts of 4; 12 `V&H` cycles; `frame_done` once, at start+21; `busy` 23 cycles; `frame_cnt`=1.
- `frames`=3 → 69 contiguous busy cycles; `frame_done` at offsets 21, 44, 67; `frame_cnt`=3; IDLE afterwards.
- `frames`=0, `stop` during frame 2 ACTIVE → frame 2 completes fully, then IDLE; `frame_cnt`=2; a late `start` during frame 2 is ignored.
- `start` and `stop` in the same cycle with `frames`=0 → exactly one frame (23 busy cycles), `frame_cnt`=1.
- `rst` asserted during the ACTIVE state of line 1 → next cycle all outputs 0; a subsequent `start` produces a clean full frame with `line_idx` starting at 0.
- `stop` pulse in IDLE, then `start` with `frames`=2 → 2 full frames; the earlier stop has no effect.
